// File: rtl/nios_simple_pio_pkg.sv
// Shared register map and helpers for the nios_simple_pio input PIO.
package nios_simple_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN      = 3'd4;
  localparam logic [2:0] ADDR_LEVEL_EN     = 3'd5;

  // Counter width that can hold 0 .. cycles-1; never narrower than one bit.
  function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/nios_simple_pio_debounce.sv
// One-channel debounce filter: filt_o follows s2_i only after it has been
// stable and different from filt_o for DEBOUNCE_CYCLES consecutive cycles.
module nios_simple_pio_debounce
  import nios_simple_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic s2_i,
  output logic filt_o
);

  localparam int unsigned CW = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (s2_i != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = s2_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/nios_simple_pio_in_irq.sv
// Avalon-MM input PIO with per-bit rise/fall/level interrupt capture.
// Optional debounce filter enabled by defining NIOS_SIMPLE_PIO_DEBOUNCE_EN.
module nios_simple_pio_in_irq
  import nios_simple_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("nios_simple_pio_in_irq: WIDTH must be 1..32 and DEBOUNCE_CYCLES >= 2");
  end

  logic [WIDTH-1:0] s1_q, s2_q, filt, filt_d_q;
  logic [WIDTH-1:0] rise_en_q, rise_en_d, mask_q, mask_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d, level_en_q, level_en_d;
  logic [WIDTH-1:0] cap_q, cap_d, evt, clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr;
  logic             unused_writedata;

  assign unused_writedata = &{1'b0, writedata};

`ifdef NIOS_SIMPLE_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    nios_simple_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .s2_i   (s2_q[i]),
      .filt_o (filt[i])
    );
  end
`else
  assign filt = s2_q;
`endif

  assign wr  = chipselect && !write_n;
  assign evt = (rise_en_q & filt & ~filt_d_q)
             | (fall_en_q & ~filt & filt_d_q)
             | (level_en_q & filt);
  assign clr = (wr && address == ADDR_EDGE_CAPTURE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rise_en_d  = rise_en_q;
    mask_d     = mask_q;
    fall_en_d  = fall_en_q;
    level_en_d = level_en_q;
    // Event is OR-ed in after the clear so a coincident edge is never lost.
    cap_d      = (cap_q & ~clr) | evt;
    if (wr) begin
      case (address)
        ADDR_RISE_EN:  rise_en_d  = writedata[WIDTH-1:0];
        ADDR_IRQ_MASK: mask_d     = writedata[WIDTH-1:0];
        ADDR_FALL_EN:  fall_en_d  = writedata[WIDTH-1:0];
        ADDR_LEVEL_EN: level_en_d = writedata[WIDTH-1:0];
        default:       ;
      endcase
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:         readdata_d[WIDTH-1:0] = filt;
      ADDR_RISE_EN:      readdata_d[WIDTH-1:0] = rise_en_q;
      ADDR_IRQ_MASK:     readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAPTURE: readdata_d[WIDTH-1:0] = cap_q;
      ADDR_FALL_EN:      readdata_d[WIDTH-1:0] = fall_en_q;
      ADDR_LEVEL_EN:     readdata_d[WIDTH-1:0] = level_en_q;
      default:           ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      filt_d_q   <= '0;
      rise_en_q  <= '0;
      mask_q     <= '0;
      fall_en_q  <= '0;
      level_en_q <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      s1_q       <= in_port;
      s2_q       <= s1_q;
      filt_d_q   <= filt;
      rise_en_q  <= rise_en_d;
      mask_q     <= mask_d;
      fall_en_q  <= fall_en_d;
      level_en_q <= level_en_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_simple_pio_in_irq.sv
// Directed plus randomized bench for nios_simple_pio_in_irq (default build, WIDTH=4).
module tb_nios_simple_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = '0;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  nios_simple_pio_in_irq #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference model: input history as a delay line plus software-visible registers.
  logic [3:0]  hist[$];
  logic [3:0]  m_rise, m_mask, m_cap, m_fall, m_level;
  logic [31:0] m_rd;

  function automatic logic [3:0] hist_ago(input int n);
    if (hist.size() > n) return hist[hist.size() - 1 - n];
    return 4'h0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_rise = '0; m_mask = '0; m_cap = '0; m_fall = '0; m_level = '0; m_rd = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive bus/pins, advance model, compare at the falling edge.
  task automatic tick(input logic cs, input logic wn, input logic [2:0] a,
                      input logic [31:0] wd, input logic [3:0] pin);
    logic [3:0] cur, prev, ev, clr;
    logic       wr;
    chipselect = cs; write_n = wn; address = a; writedata = wd; in_port = pin;
    cur  = hist_ago(1);
    prev = hist_ago(2);
    ev   = (m_rise & cur & ~prev) | (m_fall & ~cur & prev) | (m_level & cur);
    case (a)
      3'd0: m_rd = {28'h0, cur};
      3'd1: m_rd = {28'h0, m_rise};
      3'd2: m_rd = {28'h0, m_mask};
      3'd3: m_rd = {28'h0, m_cap};
      3'd4: m_rd = {28'h0, m_fall};
      3'd5: m_rd = {28'h0, m_level};
      default: m_rd = 32'h0;
    endcase
    wr  = cs && !wn;
    clr = (wr && a == 3'd3) ? wd[3:0] : 4'h0;
    m_cap = (m_cap & ~clr) | ev;
    if (wr && a == 3'd1) m_rise  = wd[3:0];
    if (wr && a == 3'd2) m_mask  = wd[3:0];
    if (wr && a == 3'd4) m_fall  = wd[3:0];
    if (wr && a == 3'd5) m_level = wd[3:0];
    @(posedge clk);
    hist.push_back(pin);
    if (hist.size() > 8) void'(hist.pop_front());
    @(negedge clk);
    chk("readdata", readdata, m_rd);
    chk("irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] pin);
    tick(1'b1, 1'b0, a, wd, pin);
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [3:0] pin);
    tick(1'b1, 1'b1, a, 32'h0, pin);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);

    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), 4'h0);
      chk("rst_read_zero", readdata, 32'h0);
    end

    // All inputs high: DATA follows after two edges, nothing captured.
    rd_reg(3'd0, 4'hF);
    rd_reg(3'd0, 4'hF);
    rd_reg(3'd0, 4'hF);
    chk("data_all_high", readdata, 32'hF);
    rd_reg(3'd3, 4'hF);
    chk("no_capture_unarmed", readdata, 32'h0);
    repeat (3) rd_reg(3'd0, 4'h0);

    // Rising edge on bit 0, capture exactly two cycles after the change.
    wr_reg(3'd1, 32'hFFFF_FFF1, 4'h0);
    wr_reg(3'd2, 32'h1, 4'h0);
    rd_reg(3'd3, 4'h1);
    chk("rise_irq_e0", {31'h0, irq}, 32'h0);
    rd_reg(3'd3, 4'h1);
    chk("rise_irq_e1", {31'h0, irq}, 32'h0);
    rd_reg(3'd3, 4'h1);
    chk("rise_irq_e2", {31'h0, irq}, 32'h1);
    rd_reg(3'd3, 4'h1);
    chk("rise_capture", readdata, 32'h1);
    wr_reg(3'd3, 32'h1, 4'h1);
    chk("w1c_irq_low", {31'h0, irq}, 32'h0);

    // Falling edge on bit 2 while masked, then unmask.
    wr_reg(3'd4, 32'h4, 4'h1);
    wr_reg(3'd2, 32'h0, 4'h1);
    repeat (3) rd_reg(3'd0, 4'h5);
    repeat (3) rd_reg(3'd0, 4'h1);
    rd_reg(3'd3, 4'h1);
    chk("fall_capture", readdata, 32'h4);
    chk("fall_masked_irq", {31'h0, irq}, 32'h0);
    wr_reg(3'd2, 32'h4, 4'h1);
    chk("unmask_irq", {31'h0, irq}, 32'h1);
    wr_reg(3'd3, 32'h4, 4'h1);

    // Clear of bit 1 coincident with its rising-edge detection: set wins.
    wr_reg(3'd1, 32'h2, 4'h1);
    rd_reg(3'd0, 4'h3);
    rd_reg(3'd0, 4'h3);
    wr_reg(3'd3, 32'h2, 4'h3);
    rd_reg(3'd3, 4'h3);
    chk("collision_set_wins", readdata, 32'h2);
    wr_reg(3'd3, 32'h2, 4'h3);

    // Level mode on bit 3 held high: capture cannot be cleared away.
    wr_reg(3'd5, 32'h8, 4'hB);
    repeat (3) rd_reg(3'd3, 4'hB);
    wr_reg(3'd3, 32'h8, 4'hB);
    rd_reg(3'd3, 4'hB);
    chk("level_reset", readdata, 32'h8);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      tick(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), $urandom, 4'($urandom));
    end

    // Asynchronous reset with an interrupt pending.
    wr_reg(3'd2, 32'hF, 4'hF);
    wr_reg(3'd5, 32'hF, 4'hF);
    repeat (3) rd_reg(3'd3, 4'hF);
    chk("pre_reset_irq", {31'h0, irq}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_irq", {31'h0, irq}, 32'h0);
    chk("async_rst_readdata", readdata, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 1; a < 8; a++) begin
      rd_reg(3'(a), 4'hF);
      chk("post_rst_regs", readdata, 32'h0);
    end
    repeat (3) rd_reg(3'd0, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
